// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Imported by the interface, the step datapath and the sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_CALC = 2'b10,
        S_FIX  = 2'b11
    } state_e;

    localparam int MULDIV_LATENCY = 34;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> muldiv sequencer bundle: command, MTxx, MFxx hazard.
// master = execute stage, slave = sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            mthi_we;
    logic            mtlo_we;
    logic [XLEN-1:0] wdata;
    logic            rd_req;
    logic            busy;
    logic            done;
    logic            stall;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b,
        output mthi_we, mtlo_we, wdata, rd_req,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        input  mthi_we, mtlo_we, wdata, rd_req,
        output busy, done, stall, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Accumulator layout: {upper half, lower half}, 2*XLEN bits.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opd_i,
    input  logic              div_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   add_sum;
    logic [2*XLEN:0] shl;
    logic [XLEN:0]   sub_diff;

    // Multiply: add multiplicand on LSB, shift right.
    // Divide: shift left, trial-subtract divisor, keep if non-negative.
    always_comb begin
        add_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]}
                 + (acc_i[0] ? {1'b0, opd_i} : '0);
        shl      = {acc_i, 1'b0};
        sub_diff = shl[2*XLEN:XLEN] - {1'b0, opd_i};
        acc_o    = {add_sum, acc_i[XLEN-1:1]};
        if (div_i) begin
            if (!sub_diff[XLEN]) begin
                acc_o = {sub_diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
            end else begin
                acc_o = shl[2*XLEN-1:0];
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Fixed 34-cycle sequence: PREP, ITER x CALC, FIX.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic clk,
    input  logic reset,
    muldiv_sequencer_if.slave bus
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW = 2 * XLEN;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            dz_q, dz_d;
    logic            done_q, done_d;

    logic            is_div;
    logic            is_sgn;
    logic            na;
    logic            nb;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [AW-1:0]   acc_step;
    logic [AW-1:0]   prod;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic            busy;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .acc_i (acc_q),
        .opd_i (opd_q),
        .div_i (is_div),
        .acc_o (acc_step)
    );

    // Operand decode: magnitudes, signs and sign-corrected results.
    always_comb begin
        is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
        is_sgn = (op_q == OP_MULT) || (op_q == OP_DIV);
        na     = is_sgn & a_q[XLEN-1];
        nb     = is_sgn & b_q[XLEN-1];
        abs_a  = na ? -a_q : a_q;
        abs_b  = nb ? -b_q : b_q;
        prod   = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo    = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0]
                                     : acc_q[XLEN-1:0];
        rem    = neg_a_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    end

    // Next-state and datapath updates for the sequence FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.mthi_we) hi_d = bus.wdata;
                if (bus.mtlo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_a_d = na;
                neg_b_d = nb;
                dz_d    = (b_q == '0);
                cnt_d   = '0;
                if (is_div) begin
                    acc_d = {{XLEN{1'b0}}, abs_a};
                    opd_d = abs_b;
                end else begin
                    acc_d = {{XLEN{1'b0}}, abs_b};
                    opd_d = abs_a;
                end
                state_d = S_CALC;
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                unique case (1'b1)
                    (is_div && dz_q): begin
                        hi_d = a_q;
                        lo_d = '1;
                    end
                    (is_div && !dz_q): begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    (!is_div): begin
                        hi_d = prod[AW-1:XLEN];
                        lo_d = prod[XLEN-1:0];
                    end
                    default: ;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    // Status and hazard outputs.
    always_comb begin
        busy      = (state_q != S_IDLE);
        bus.busy  = busy;
        bus.stall = busy & (bus.rd_req | bus.start
                          | bus.mthi_we | bus.mtlo_we);
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

endmodule
